// File: rtl/alu_arb_if.sv
// Bundle between the alu_arb block, its two requesters, the shared ALU and the result consumer.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface alu_arb_if #(
    parameter int XLEN = 32
);
    logic            req0_valid;
    logic            req0_ready;
    logic [XLEN-1:0] req0_a;
    logic [XLEN-1:0] req0_b;
    logic [3:0]      req0_ctrl;
    logic [2:0]      req0_ctrl1;

    logic            req1_valid;
    logic            req1_ready;
    logic [XLEN-1:0] req1_a;
    logic [XLEN-1:0] req1_b;
    logic [3:0]      req1_ctrl;
    logic [2:0]      req1_ctrl1;

    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_ctrl;
    logic [2:0]      alu_ctrl1;
    logic [XLEN-1:0] alu_out;

    logic            resp_valid;
    logic            resp_ready;
    logic            resp_id;
    logic [XLEN-1:0] resp_data;
    logic [1:0]      cnt;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl, req0_ctrl1,
        input  req1_valid, req1_a, req1_b, req1_ctrl, req1_ctrl1,
        input  alu_out, resp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_ctrl, alu_ctrl1,
        output resp_valid, resp_id, resp_data, cnt
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl, req0_ctrl1,
        output req1_valid, req1_a, req1_b, req1_ctrl, req1_ctrl1,
        output alu_out, resp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_ctrl, alu_ctrl1,
        input  resp_valid, resp_id, resp_data, cnt
    );
endinterface

// File: rtl/alu_arb.sv
// Round-robin arbiter in front of the shared single-cycle ALU, with a 2-entry tagged result FIFO.
// The winner's operands go straight to the ALU and the result is captured on the same edge.
module alu_arb #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rstn,
    alu_arb_if.slave   bus
);
    logic                 space;
    logic                 push;
    logic                 pop;
    logic                 grant0;
    logic                 grant1;
    logic                 last;
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;
    logic [1:0][XLEN-1:0] fifo_data;
    logic [1:0]           fifo_id;

    // Grants are gated by rstn so ready stays low while reset is held.
    always_comb begin
        pop    = (count != 2'd0) & bus.resp_ready;
        space  = rstn & ((count < 2'd2) | pop);
        grant0 = space & bus.req0_valid & (~bus.req1_valid | last);
        grant1 = space & bus.req1_valid & (~bus.req0_valid | ~last);
        push   = grant0 | grant1;
    end

    always_comb begin
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_ctrl  = '0;
        bus.alu_ctrl1 = '0;
        if (grant0) begin
            bus.alu_a     = bus.req0_a;
            bus.alu_b     = bus.req0_b;
            bus.alu_ctrl  = bus.req0_ctrl;
            bus.alu_ctrl1 = bus.req0_ctrl1;
        end else if (grant1) begin
            bus.alu_a     = bus.req1_a;
            bus.alu_b     = bus.req1_b;
            bus.alu_ctrl  = bus.req1_ctrl;
            bus.alu_ctrl1 = bus.req1_ctrl1;
        end
    end

    // A push at count==2 always coincides with a pop, so wr_ptr==rd_ptr and
    // the write lands in the slot being freed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last      <= 1'b1;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            fifo_data <= '0;
            fifo_id   <= '0;
        end else begin
            if (push) begin
                last              <= grant1;
                fifo_data[wr_ptr] <= bus.alu_out;
                fifo_id[wr_ptr]   <= grant1;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.resp_valid = (count != 2'd0);
    assign bus.resp_data  = fifo_data[rd_ptr];
    assign bus.resp_id    = fifo_id[rd_ptr];
    assign bus.cnt        = count;
endmodule
